pattern_detect_scheduler: RTL

Time-shares one "1011" serial pattern-detection engine across NUM_CH independent bit-stream requesters. A round-robin arbiter accepts at most one bit per cycle. The accepted bit advances that channel's saved detector context, and the new context is written back. The block reports hits per channel and keeps a saturating hit count for each channel. It sits between the serial ingress lanes and the status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/pattern_detect_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the "1011" serial pattern detector: the saved
// per-channel context encoding and the single-bit step function.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        GOT_1   = 3'b001,
        GOT_10  = 3'b010,
        GOT_101 = 3'b011,
        FOUND   = 3'b100
    } state_t;

    // Advance one context by one bit; overlap is kept so "10110" ends in GOT_10.
    // Unused encodings fall back to IDLE whatever the bit.
    function automatic state_t det_step(input state_t cur, input logic bit_in);
        state_t nxt;
        case (cur)
            IDLE:    nxt = bit_in ? GOT_1   : IDLE;
            GOT_1:   nxt = bit_in ? GOT_1   : GOT_10;
            GOT_10:  nxt = bit_in ? GOT_101 : IDLE;
            GOT_101: nxt = bit_in ? FOUND   : GOT_10;
            FOUND:   nxt = bit_in ? GOT_1   : GOT_10;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// rotating pointer, and moves the pointer just past each winner.
module rr_arbiter #(
    parameter int  NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] eligible,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] rr_ptr;
    int              cand;
    logic [CH_W-1:0] cand_idx;

    // Scan NUM_CH positions starting at rr_ptr (modulo NUM_CH) and take the first eligible one.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = CH_W'(cand);
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid     = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    // Pointer moves one past the winner (wrapping), and holds when nobody wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Time-shared "1011" detector: one step engine serves NUM_CH serial lanes,
// each lane keeping its own saved context and saturating hit counter.
//
// Handshake: lane i moves a bit in a cycle when ch_valid[i] and ch_ready[i]
// are both high at the clock edge. ch_ready is combinational, one-hot or zero,
// never raised for a lane that is being cleared, and is zero during reset. A
// lane that sees valid without ready keeps its bit and presents it again.
module pattern_detect_scheduler
    import seq_det_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH-1:0]      ch_data,
    output logic [NUM_CH-1:0]      ch_ready,
    input  logic [NUM_CH-1:0]      ch_clear,
    output logic                   hit_valid,
    output logic [CH_W-1:0]        hit_ch,
    input  logic [CH_W-1:0]        rd_sel,
    output logic [CNT_W-1:0]       rd_count,
    output logic [NUM_CH-1:0][2:0] dbg_ctx
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             ctx [NUM_CH];
    logic [CNT_W-1:0]   cnt [NUM_CH];

    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  grant;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_valid;
    state_t             step_ctx;

    // A lane competes only when it has a bit, is not being cleared, and reset is released.
    always_comb begin
        eligible = ch_valid & ~ch_clear & {NUM_CH{rst_n}};
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .eligible    (eligible),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grant doubles as ready; run the shared step engine on the winner's saved context.
    always_comb begin
        ch_ready = grant;
        step_ctx = det_step(ctx[grant_idx], ch_data[grant_idx]);
    end

    // Per-lane context and counter: clear wins, otherwise only the winner is written back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx[i] <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i]) begin
                    ctx[i] <= IDLE;
                    cnt[i] <= '0;
                end else if (grant_valid && (grant_idx == CH_W'(i))) begin
                    ctx[i] <= step_ctx;
                    if ((step_ctx == FOUND) && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Hit pulse for one cycle after the completing bit; hit_ch keeps the last hitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid <= 1'b0;
            hit_ch    <= '0;
        end else begin
            hit_valid <= grant_valid && (step_ctx == FOUND);
            if (grant_valid && (step_ctx == FOUND)) begin
                hit_ch <= grant_idx;
            end
        end
    end

    // Counter readback sees the value from before this cycle's increment or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (int'(rd_sel) < NUM_CH) begin
            rd_count <= cnt[rd_sel];
        end else begin
            rd_count <= '0;
        end
    end

    // Expose every lane's saved context for observation.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dbg_ctx[i] = ctx[i];
        end
    end

endmodule
